// File: rtl/vc_credit_output_arbiter_if.sv
// Flit link bundle between the router input modules, the output arbiter and the
// inter-router link: N input flit ports in, one registered output flit port out.
interface vc_credit_output_arbiter_if #(
  parameter int NumInputs  = 4,
  parameter int NumVirtChn = 2,
  parameter int FlitWidth  = 64
);
  localparam int VcWidth = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;

  logic [NumInputs-1:0]           in_valid_i;
  logic [NumInputs*VcWidth-1:0]   in_vc_i;
  logic [NumInputs-1:0]           in_head_i;
  logic [NumInputs-1:0]           in_tail_i;
  logic [NumInputs*FlitWidth-1:0] in_data_i;
  logic [NumInputs-1:0]           in_ready_o;

  logic                           out_valid_o;
  logic [VcWidth-1:0]             out_vc_o;
  logic                           out_head_o;
  logic                           out_tail_o;
  logic [FlitWidth-1:0]           out_data_o;

  modport slave (
    input  in_valid_i, in_vc_i, in_head_i, in_tail_i, in_data_i,
    output in_ready_o, out_valid_o, out_vc_o, out_head_o, out_tail_o, out_data_o
  );

  modport master (
    output in_valid_i, in_vc_i, in_head_i, in_tail_i, in_data_i,
    input  in_ready_o, out_valid_o, out_vc_o, out_head_o, out_tail_o, out_data_o
  );
endinterface

// File: rtl/vc_credit_output_arbiter.sv
// Router output stage: N inputs x V virtual channels onto one registered link,
// with per-VC wormhole locks, round-robin input choice and per-VC credit counters.
module vc_credit_output_arbiter #(
  parameter int NumInputs   = 4,
  parameter int NumVirtChn  = 2,
  parameter int FlitWidth   = 64,
  parameter int BufferDepth = 4,
  parameter int VcArbMode   = 0,
  localparam int VcWidth    = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1,
  localparam int CntWidth   = $clog2(BufferDepth + 1)
) (
  input  logic                           clk,
  input  logic                           arst,
  vc_credit_output_arbiter_if.slave      bus,
  input  logic [NumVirtChn-1:0]          credit_ret_i,
  output logic [NumVirtChn*CntWidth-1:0] credits_o,
  output logic [NumVirtChn-1:0]          vc_locked_o,
  output logic                           credit_err_o
);
  localparam int InWidth = $clog2(NumInputs);

  typedef logic [VcWidth-1:0]  vc_t;
  typedef logic [InWidth-1:0]  in_t;
  typedef logic [CntWidth-1:0] cnt_t;

  cnt_t                 r_credits [NumVirtChn];
  logic [NumVirtChn-1:0] r_lock;
  in_t                  r_owner   [NumVirtChn];
  in_t                  r_in_ptr  [NumVirtChn];
  vc_t                  r_vc_ptr;
  logic                 r_cred_err;
  logic                 r_out_valid;
  vc_t                  r_out_vc;
  logic                 r_out_head;
  logic                 r_out_tail;
  logic [FlitWidth-1:0] r_out_data;

  logic [NumInputs-1:0]  w_elig [NumVirtChn];
  logic [NumVirtChn-1:0] w_cand;
  logic [NumInputs-1:0]  w_elig_sel;
  logic                  w_accept;
  vc_t                   w_vc_sel;
  in_t                   w_in_sel;
  logic                  w_sel_head;
  logic                  w_sel_tail;
  logic [FlitWidth-1:0]  w_sel_data;
  logic [NumVirtChn-1:0] w_send;

  // Maps scan position k (0 = highest priority) to a VC index for the chosen mode.
  function automatic int prio_vc(input int k, input int ptr);
    case (VcArbMode)
      0:       return NumVirtChn - 1 - k;
      1:       return k;
      default: return (ptr + k) % NumVirtChn;
    endcase
  endfunction

  always_comb begin
    for (int v = 0; v < NumVirtChn; v++) begin
      for (int i = 0; i < NumInputs; i++) begin
        w_elig[v][i] = bus.in_valid_i[i]
                    && (bus.in_vc_i[i*VcWidth +: VcWidth] == vc_t'(v))
                    && (r_lock[v] ? (r_owner[v] == in_t'(i)) : bus.in_head_i[i]);
      end
      w_cand[v] = (|w_elig[v]) && (r_credits[v] != '0);
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int v;
    // NOTE: every combinational output gets a default before the scan; a path
    // that leaves one unassigned would infer a latch.
    v          = 0;
    w_accept   = 1'b0;
    w_vc_sel   = '0;
    w_elig_sel = '0;
    for (int k = NumVirtChn - 1; k >= 0; k--) begin
      v = prio_vc(k, int'(r_vc_ptr));
      if (w_cand[v]) begin
        w_accept   = 1'b1;
        w_vc_sel   = vc_t'(v);
        w_elig_sel = w_elig[v];
      end
    end
  end

  // A locked VC has only its owner eligible, so the same scan serves both cases.
  always_comb begin
    int i;
    i        = 0;
    w_in_sel = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      i = (int'(r_in_ptr[w_vc_sel]) + k) % NumInputs;
      if (w_elig_sel[i]) w_in_sel = in_t'(i);
    end
  end

  assign w_sel_head     = bus.in_head_i[w_in_sel];
  assign w_sel_tail     = bus.in_tail_i[w_in_sel];
  assign w_sel_data     = bus.in_data_i[w_in_sel*FlitWidth +: FlitWidth];
  assign w_send         = w_accept ? (NumVirtChn'(1) << w_vc_sel) : '0;
  assign bus.in_ready_o = w_accept ? (NumInputs'(1) << w_in_sel) : '0;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_out_valid <= 1'b0;
      r_out_vc    <= '0;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_data  <= '0;
      r_lock      <= '0;
      r_vc_ptr    <= '0;
      r_cred_err  <= 1'b0;
      // NOTE: these per-VC arrays are control state, not storage, so every
      // entry is reset; payload-only memories would be left unreset.
      for (int v = 0; v < NumVirtChn; v++) begin
        r_credits[v] <= cnt_t'(BufferDepth);
        r_owner[v]   <= '0;
        r_in_ptr[v]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_out_valid <= w_accept;
      r_out_vc    <= w_vc_sel;
      r_out_head  <= w_accept & w_sel_head;
      r_out_tail  <= w_accept & w_sel_tail;
      r_out_data  <= w_sel_data;
      for (int v = 0; v < NumVirtChn; v++) begin
        if (w_send[v] && !credit_ret_i[v]) begin
          r_credits[v] <= r_credits[v] - cnt_t'(1);
        end else if (!w_send[v] && credit_ret_i[v]) begin
          if (r_credits[v] == cnt_t'(BufferDepth)) r_cred_err <= 1'b1;
          else                                    r_credits[v] <= r_credits[v] + cnt_t'(1);
        end
      end
      if (w_accept) begin
        if (w_sel_head && !w_sel_tail) begin
          r_lock[w_vc_sel]  <= 1'b1;
          r_owner[w_vc_sel] <= w_in_sel;
        end else if (w_sel_tail) begin
          r_lock[w_vc_sel]  <= 1'b0;
        end
        if (w_sel_head) r_in_ptr[w_vc_sel] <= in_t'((int'(w_in_sel) + 1) % NumInputs);
        r_vc_ptr <= vc_t'((int'(w_vc_sel) + 1) % NumVirtChn);
      end
    end
  end

  for (genvar v = 0; v < NumVirtChn; v++) begin : g_cred
    assign credits_o[v*CntWidth +: CntWidth] = r_credits[v];
  end

  assign vc_locked_o     = r_lock;
  assign credit_err_o    = r_cred_err;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_vc_o    = r_out_vc;
  assign bus.out_head_o  = r_out_head;
  assign bus.out_tail_o  = r_out_tail;
  assign bus.out_data_o  = r_out_data;
endmodule

// File: tb/tb_vc_credit_output_arbiter.sv
// Three arbiters (VC modes 0, 1, 2) fed from per-instance packet sources; a
// packet-level reference model predicts ready and output flits into scoreboards.
module tb_vc_credit_output_arbiter;
  localparam int NI = 4, NV = 2, FW = 64, BD = 4, VW = 1, CW = 3, NDUT = 3;

  typedef struct { int vc; bit head; bit tail; logic [FW-1:0] data; } flit_t;
  typedef struct { int vc; bit head; bit tail; logic [FW-1:0] data; int tag; } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]    d_valid [NDUT];
  logic [NI*VW-1:0] d_vc    [NDUT];
  logic [NI-1:0]    d_head  [NDUT];
  logic [NI-1:0]    d_tail  [NDUT];
  logic [NI*FW-1:0] d_data  [NDUT];
  logic [NV-1:0]    d_ret   [NDUT];
  logic [NI-1:0]    ready   [NDUT];
  logic             o_valid [NDUT];
  logic [VW-1:0]    o_vc    [NDUT];
  logic             o_head  [NDUT];
  logic             o_tail  [NDUT];
  logic [FW-1:0]    o_data  [NDUT];
  logic [NV*CW-1:0] o_cred  [NDUT];
  logic [NV-1:0]    o_lock  [NDUT];
  logic             o_err   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    vc_credit_output_arbiter_if #(.NumInputs(NI), .NumVirtChn(NV), .FlitWidth(FW)) bus ();
    assign bus.in_valid_i = d_valid[g];
    assign bus.in_vc_i    = d_vc[g];
    assign bus.in_head_i  = d_head[g];
    assign bus.in_tail_i  = d_tail[g];
    assign bus.in_data_i  = d_data[g];
    assign ready[g]   = bus.in_ready_o;
    assign o_valid[g] = bus.out_valid_o;
    assign o_vc[g]    = bus.out_vc_o;
    assign o_head[g]  = bus.out_head_o;
    assign o_tail[g]  = bus.out_tail_o;
    assign o_data[g]  = bus.out_data_o;
    vc_credit_output_arbiter #(
      .NumInputs(NI), .NumVirtChn(NV), .FlitWidth(FW), .BufferDepth(BD), .VcArbMode(g)
    ) u_dut (
      .clk          (clk),
      .arst         (arst),
      .bus          (bus),
      .credit_ret_i (d_ret[g]),
      .credits_o    (o_cred[g]),
      .vc_locked_o  (o_lock[g]),
      .credit_err_o (o_err[g])
    );
  end

  // Reference state: what the downstream hop and the packet rules imply.
  int    m_cred  [NDUT][NV];
  bit    m_lock  [NDUT][NV];
  int    m_owner [NDUT][NV];
  int    m_inptr [NDUT][NV];
  int    m_vcptr [NDUT];
  bit    m_err   [NDUT];
  flit_t src     [NDUT][NI][$];
  exp_t  sbq     [NDUT][$];

  int n_total = 0, n_pass = 0, cyc = 0;
  bit auto_ret = 1'b0;
  logic [NV-1:0] force_ret = '0;

  task automatic check(input string name, input int d, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc%0d: got %h expected %h", name, d, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int v = 0; v < NV; v++) begin
        m_cred[d][v] = BD; m_lock[d][v] = 1'b0; m_owner[d][v] = 0; m_inptr[d][v] = 0;
      end
      m_vcptr[d] = 0; m_err[d] = 1'b0;
      for (int i = 0; i < NI; i++) src[d][i].delete();
    end
  endtask

  task automatic add_pkt(input int inp, input int vc, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.vc = vc; f.head = (k == 0); f.tail = (k == len - 1); f.data = {$urandom(), $urandom()};
      for (int d = 0; d < NDUT; d++) src[d][inp].push_back(f);
    end
  endtask

  task automatic drive();
    flit_t f;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < NI; i++) begin
        if (src[d][i].size() > 0) begin
          f = src[d][i][0];
          d_valid[d][i] = 1'b1; d_vc[d][i*VW +: VW] = VW'(f.vc);
          d_head[d][i] = f.head; d_tail[d][i] = f.tail; d_data[d][i*FW +: FW] = f.data;
        end else begin
          d_valid[d][i] = 1'b0; d_vc[d][i*VW +: VW] = VW'($urandom());
          d_head[d][i] = 1'($urandom()); d_tail[d][i] = 1'($urandom());
          d_data[d][i*FW +: FW] = {$urandom(), $urandom()};
        end
      end
      for (int v = 0; v < NV; v++)
        d_ret[d][v] = force_ret[v] | (auto_ret && m_cred[d][v] < BD && $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic model_eval();
    for (int d = 0; d < NDUT; d++) begin
      logic [NI-1:0]    exp_rdy;
      logic [NV*CW-1:0] exp_cr;
      logic [NV-1:0]    exp_lk;
      bit cand [NV];
      bit el   [NV][NI];
      int wv, wi, v, i;
      bit send;
      flit_t f;
      exp_t e;
      for (int k = 0; k < NV; k++) begin
        exp_cr[k*CW +: CW] = CW'(m_cred[d][k]); exp_lk[k] = m_lock[d][k];
      end
      check("credits", d, o_cred[d], exp_cr);
      check("vc_locked", d, o_lock[d], exp_lk);
      check("credit_err", d, o_err[d], m_err[d]);
      for (int k = 0; k < NV; k++) begin
        cand[k] = 1'b0;
        for (int n = 0; n < NI; n++) begin
          el[k][n] = src[d][n].size() > 0 && src[d][n][0].vc == k
                  && (m_lock[d][k] ? m_owner[d][k] == n : src[d][n][0].head);
          if (el[k][n] && m_cred[d][k] > 0) cand[k] = 1'b1;
        end
      end
      wv = -1;
      if (d == 0)      begin for (int k = 0; k < NV; k++) if (cand[k]) wv = k; end
      else if (d == 1) begin for (int k = NV - 1; k >= 0; k--) if (cand[k]) wv = k; end
      else for (int k = 0; k < NV; k++) begin
        v = (m_vcptr[d] + k) % NV;
        if (wv < 0 && cand[v]) wv = v;
      end
      wi = -1;
      if (wv >= 0) begin
        if (m_lock[d][wv]) wi = m_owner[d][wv];
        else for (int k = 0; k < NI; k++) begin
          i = (m_inptr[d][wv] + k) % NI;
          if (wi < 0 && el[wv][i]) wi = i;
        end
      end
      exp_rdy = (wi >= 0) ? NI'(1 << wi) : '0;
      check("in_ready", d, ready[d], exp_rdy);
      for (int k = 0; k < NV; k++) begin
        send = (k == wv);
        if (send && !d_ret[d][k]) m_cred[d][k]--;
        else if (!send && d_ret[d][k]) begin
          if (m_cred[d][k] == BD) m_err[d] = 1'b1;
          else m_cred[d][k]++;
        end
      end
      if (wi >= 0) begin
        f = src[d][wi].pop_front();
        e.vc = f.vc; e.head = f.head; e.tail = f.tail; e.data = f.data; e.tag = cyc;
        sbq[d].push_back(e);
        if (f.head && !f.tail) begin m_lock[d][wv] = 1'b1; m_owner[d][wv] = wi; end
        else if (f.tail) m_lock[d][wv] = 1'b0;
        if (f.head) m_inptr[d][wv] = (wi + 1) % NI;
        m_vcptr[d] = (wv + 1) % NV;
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_empty();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < NI; i++) if (src[d][i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit creds_full();
    for (int d = 0; d < NDUT; d++)
      for (int v = 0; v < NV; v++) if (m_cred[d][v] != BD) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int bound);
    for (int n = 0; n < bound && !all_empty(); n++) step();
  endtask

  task automatic settle();
    auto_ret = 1'b1;
    for (int n = 0; n < 60 && !creds_full(); n++) step();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin d_valid[d] = '0; d_ret[d] = '0; end
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
  endtask

  // Output monitor: pops the scoreboard whenever an instance presents a flit.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
        if (o_valid[d] === 1'b1) begin
          if (sbq[d].size() == 0) check("spurious_out", d, 1, 0);
          else begin
            e = sbq[d].pop_front();
            check("out_flit", d, {o_vc[d], o_head[d], o_tail[d], o_data[d]},
                  {VW'(e.vc), e.head, e.tail, e.data});
            check("out_latency", d, cyc - 1, e.tag);
          end
        end else if (sbq[d].size() != 0 && sbq[d][0].tag == cyc - 1) begin
          e = sbq[d].pop_front();
          check("missing_out", d, 0, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      d_valid[d] = '0; d_vc[d] = '0; d_head[d] = '0; d_tail[d] = '0; d_data[d] = '0; d_ret[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();

    // Single-flit packet on input 2, VC1.
    add_pkt(2, 1, 1);
    repeat (3) step();

    // Wormhole on VC0: input 0 three-flit packet versus input 1 head.
    add_pkt(0, 0, 3);
    add_pkt(1, 0, 1);
    auto_ret = 1'b1;
    drain(40);

    // Credit stall on VC0 and release by a single return pulse.
    settle();
    auto_ret = 1'b0;
    add_pkt(3, 0, 6);
    repeat (8) step();
    force_ret = 2'b01;
    step();
    force_ret = '0;
    repeat (4) step();
    auto_ret = 1'b1;
    drain(60);

    // Both VCs backlogged: the modes diverge.
    settle();
    add_pkt(0, 0, 6);
    add_pkt(1, 1, 6);
    add_pkt(2, 0, 3);
    add_pkt(3, 1, 3);
    drain(120);

    // Return into a full counter: sticky overflow flag.
    settle();
    auto_ret = 1'b0;
    force_ret = 2'b01;
    step();
    force_ret = '0;
    repeat (3) step();

    // Reset mid-packet with VC0 locked and one credit left.
    add_pkt(0, 0, 4);
    repeat (3) step();
    do_reset();
    begin
      flit_t f;
      f.vc = 0; f.head = 1'b0; f.tail = 1'b0; f.data = {$urandom(), $urandom()};
      for (int d = 0; d < NDUT; d++) src[d][0].push_back(f);
    end
    add_pkt(1, 0, 1);
    repeat (4) step();
    for (int d = 0; d < NDUT; d++) src[d][0].delete();

    // Randomised traffic with random credit returns.
    auto_ret = 1'b1;
    repeat (400) begin
      int i;
      i = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 2) == 0 && src[0][i].size() < 8)
        add_pkt(i, $urandom_range(0, NV - 1), $urandom_range(1, 4));
      step();
    end
    drain(400);
    repeat (3) step();
    for (int d = 0; d < NDUT; d++) check("scoreboard_empty", d, sbq[d].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
